// File: rtl/flag_ctrl.sv
// CPU status register {N,Z,O,C}: merges ALU and flag-instruction writes, and moves
// the flags to and from memory for interrupt save/restore over a req/ack handshake.
module flag_ctrl #(
  parameter int unsigned MEM_W   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [3:0]       alu_flags,
  input  logic [3:0]       alu_mask,
  input  logic             op_valid,
  input  logic [3:0]       operator,
  input  logic             save_req,
  input  logic             restore_req,
  output logic             mem_req,
  output logic             mem_we,
  output logic [MEM_W-1:0] mem_wdata,
  input  logic [MEM_W-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned TIMER_W = 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SAVE    = 2'd1;
  localparam logic [1:0] ST_RESTORE = 2'd2;

  // Flag opcodes: bit3 marks a flag op, bit2 selects set, bits[1:0] index {N,Z,O,C}.
  localparam logic [3:0] OP_CLC = 4'h8;
  localparam logic [3:0] OP_CLO = 4'h9;
  localparam logic [3:0] OP_CLZ = 4'hA;
  localparam logic [3:0] OP_CLN = 4'hB;
  localparam logic [3:0] OP_STC = 4'hC;
  localparam logic [3:0] OP_STO = 4'hD;
  localparam logic [3:0] OP_STZ = 4'hE;
  localparam logic [3:0] OP_STN = 4'hF;

  logic [1:0]         state_q,     state_d;
  logic [3:0]         flags_q,     flags_d;
  logic [TIMER_W-1:0] timer_q,     timer_d;
  logic               mem_req_q,   mem_req_d;
  logic               mem_we_q,    mem_we_d;
  logic [MEM_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;
  logic               err_q,       err_d;

  logic [3:0]         wr_flags_c;
  logic               flag_op_c;
  logic [MEM_W-5:0]   unused_rdata_c;

  assign unused_rdata_c = mem_rdata[MEM_W-1:4];

  always_comb begin
    flag_op_c = 1'b0;
    case (operator)
      OP_CLC, OP_CLO, OP_CLZ, OP_CLN,
      OP_STC, OP_STO, OP_STZ, OP_STN: flag_op_c = 1'b1;
      default:                        flag_op_c = 1'b0;
    endcase
  end

  // ALU merge first, then the flag instruction overrides its single bit.
  always_comb begin
    wr_flags_c = flags_q;
    if (alu_valid) begin
      wr_flags_c = (flags_q & ~alu_mask) | (alu_flags & alu_mask);
    end
    if (op_valid && flag_op_c) begin
      wr_flags_c[operator[1:0]] = operator[2];
    end
  end

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    timer_d     = timer_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (restore_req) begin
          state_d   = ST_RESTORE;
          mem_req_d = 1'b1;
          mem_we_d  = 1'b0;
          busy_d    = 1'b1;
          timer_d   = '0;
        end else begin
          flags_d = wr_flags_c;
          if (save_req) begin
            state_d     = ST_SAVE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = MEM_W'(wr_flags_c);
            busy_d      = 1'b1;
            timer_d     = '0;
          end
        end
      end

      ST_SAVE, ST_RESTORE: begin
        if (mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          timer_d   = '0;
          if (state_q == ST_RESTORE) begin
            flags_d = mem_rdata[3:0];
          end
        end else if (timer_q == TIMER_W'(TIMEOUT - 1)) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
          busy_d    = 1'b0;
          err_d     = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
        busy_d    = 1'b0;
        timer_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      flags_q     <= '0;
      timer_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      timer_q     <= timer_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign flags     = flags_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
